// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: sequences ALU results and load returns
// onto the single register-file write port; loads always win.
module wb_port_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [DATA_W-1:0] alu_data,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [ADDR_W-1:0] mem_rd,
  output logic              wb_en,
  output logic              wb_sel,
  output logic [DATA_W-1:0] wb_res,
  output logic [DATA_W-1:0] wb_mem,
  output logic [ADDR_W-1:0] wb_rd,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   hold_data_q, hold_data_d;
  logic [ADDR_W-1:0]   hold_rd_q, hold_rd_d;
  logic                wb_en_q, wb_en_d;
  logic                wb_sel_q, wb_sel_d;
  logic [DATA_W-1:0]   wb_res_q, wb_res_d;
  logic [DATA_W-1:0]   wb_mem_q, wb_mem_d;
  logic [ADDR_W-1:0]   wb_rd_q, wb_rd_d;
  logic [CNT_W-1:0]    stall_q, stall_d;

  logic                alu_acc;
  logic                stall_now;

  assign alu_ready = !rst && (state_q == EMPTY);
  assign alu_acc   = alu_valid && alu_ready;
  assign stall_now = alu_valid && !alu_ready && !rst;

  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    hold_rd_d   = hold_rd_q;
    wb_en_d     = 1'b0;
    wb_sel_d    = wb_sel_q;
    wb_res_d    = wb_res_q;
    wb_mem_d    = wb_mem_q;
    wb_rd_d     = wb_rd_q;
    unique case (state_q)
      EMPTY: begin
        if (mem_valid) begin
          wb_en_d  = (mem_rd != '0);
          wb_sel_d = 1'b1;
          wb_mem_d = mem_data;
          wb_rd_d  = mem_rd;
          if (alu_acc) begin
            hold_data_d = alu_data;
            hold_rd_d   = alu_rd;
            state_d     = FULL;
          end
        end else if (alu_acc) begin
          wb_en_d  = (alu_rd != '0);
          wb_sel_d = 1'b0;
          wb_res_d = alu_data;
          wb_rd_d  = alu_rd;
        end
      end
      FULL: begin
        if (mem_valid) begin
          wb_en_d  = (mem_rd != '0);
          wb_sel_d = 1'b1;
          wb_mem_d = mem_data;
          wb_rd_d  = mem_rd;
        end else begin
          wb_en_d  = (hold_rd_q != '0);
          wb_sel_d = 1'b0;
          wb_res_d = hold_data_q;
          wb_rd_d  = hold_rd_q;
          state_d  = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Stall counter sticks at all-ones once reached.
  always_comb begin
    stall_d = stall_q;
    if (stall_now && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      hold_data_q <= '0;
      hold_rd_q   <= '0;
      wb_en_q     <= 1'b0;
      wb_sel_q    <= 1'b0;
      wb_res_q    <= '0;
      wb_mem_q    <= '0;
      wb_rd_q     <= '0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_rd_q   <= hold_rd_d;
      wb_en_q     <= wb_en_d;
      wb_sel_q    <= wb_sel_d;
      wb_res_q    <= wb_res_d;
      wb_mem_q    <= wb_mem_d;
      wb_rd_q     <= wb_rd_d;
      stall_q     <= stall_d;
    end
  end

  assign wb_en     = wb_en_q;
  assign wb_sel    = wb_sel_q;
  assign wb_res    = wb_res_q;
  assign wb_mem    = wb_mem_q;
  assign wb_rd     = wb_rd_q;
  assign stall_cnt = stall_q;

endmodule
